axis_acquisition_controller: RTL and testbench

AXIS_ACQUISITION_CONTROLLER -- requirements
Module: axis_acquisition_controller

---
 rtl/axis_acquisition_controller.sv | 192 +++++++++++++++++++
 tb/tb_axis_acquisition_controller.sv | 449 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_acquisition_controller.sv
// axis_acquisition_controller: timed/event-limited acquisition run gating a
// tready-less detector stream into a buffered AXI-Stream output.
// Optional: define AXIS_ACQUISITION_CONTROLLER_DROP_CNT_EN to enable the
// sts_drops counter; otherwise sts_drops reads 0 and drops are silent.
module axis_acquisition_controller #(
    parameter int unsigned FIFO_ADDR_WIDTH = 4
) (
    input  logic         aclk,
    input  logic         areset,
    input  logic [63:0]  cfg_time,
    input  logic [31:0]  cfg_events,
    input  logic         ctrl_start,
    input  logic         ctrl_stop,
    input  logic [127:0] s_axis_tdata,
    input  logic         s_axis_tvalid,
    output logic [127:0] m_axis_tdata,
    output logic         m_axis_tvalid,
    input  logic         m_axis_tready,
    output logic         det_inhibit,
    output logic [1:0]   sts_state,
    output logic [31:0]  sts_events,
    output logic [31:0]  sts_drops
);

    localparam int unsigned DATA_W  = 128;
    localparam int unsigned DEPTH   = 1 << FIFO_ADDR_WIDTH;
    localparam int unsigned CNT_W   = FIFO_ADDR_WIDTH + 1;
    localparam int unsigned TIMER_W = 64;
    localparam int unsigned EVT_W   = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    state_e                     state_q, state_d;
    logic [TIMER_W-1:0]         timer_q, timer_d;
    logic [EVT_W-1:0]           events_q, events_d;
    logic                       det_inhibit_q, det_inhibit_d;

    logic [DATA_W-1:0]          mem_q [DEPTH];
    logic [FIFO_ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]           count_q, count_d;
    logic                       tvalid_q, tvalid_d;

    logic fifo_full;
    logic fifo_empty;
    logic in_run;
    logic push;
    logic pop;
    logic start_go;

    // Buffer status and handshake decode; full is taken before any same-cycle pop.
    always_comb begin
        fifo_full  = (count_q == CNT_W'(DEPTH));
        fifo_empty = (count_q == CNT_W'(0));
        in_run     = (state_q == ST_RUN);
        push       = in_run & s_axis_tvalid & ~fifo_full;
        pop        = ~fifo_empty & m_axis_tready;
        start_go   = ((state_q == ST_IDLE) || (state_q == ST_DONE)) &&
                     ctrl_start && (cfg_time != TIMER_W'(0)) && !ctrl_stop;
    end

    // Run sequencing: timer, accepted-event count and state transitions.
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        events_d = events_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_go) begin
                    state_d  = ST_RUN;
                    timer_d  = TIMER_W'(0);
                    events_d = EVT_W'(0);
                end
            end
            ST_RUN: begin
                timer_d = timer_q + TIMER_W'(1);
                if (push && (events_q != {EVT_W{1'b1}})) begin
                    events_d = events_q + EVT_W'(1);
                end
                if (ctrl_stop) begin
                    state_d = ST_DRAIN;
                end
                // >= rather than == so a cfg_time lowered mid-run still ends it
                if (timer_d >= cfg_time) begin
                    state_d = ST_DRAIN;
                end
                if ((cfg_events != EVT_W'(0)) && push && (events_d == cfg_events)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (fifo_empty) begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        det_inhibit_d = (state_d != ST_RUN);
    end

    // Buffer pointer and occupancy update.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + FIFO_ADDR_WIDTH'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + FIFO_ADDR_WIDTH'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        tvalid_d = (count_d != CNT_W'(0));
    end

    // Control and status registers with synchronous reset.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q       <= ST_IDLE;
            timer_q       <= '0;
            events_q      <= '0;
            det_inhibit_q <= 1'b1;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            tvalid_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            events_q      <= events_d;
            det_inhibit_q <= det_inhibit_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            tvalid_q      <= tvalid_d;
        end
    end

    // Buffer storage; contents need no reset since occupancy gates visibility.
    always_ff @(posedge aclk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= s_axis_tdata;
        end
    end

`ifdef AXIS_ACQUISITION_CONTROLLER_DROP_CNT_EN
    logic [EVT_W-1:0] drops_q, drops_d;
    logic             drop;

    // Saturating count of RUN beats lost to a full buffer.
    always_comb begin
        drop    = in_run & s_axis_tvalid & fifo_full;
        drops_d = drops_q;
        if (start_go) begin
            drops_d = EVT_W'(0);
        end else if (drop && (drops_q != {EVT_W{1'b1}})) begin
            drops_d = drops_q + EVT_W'(1);
        end
    end

    // Drop counter register.
    always_ff @(posedge aclk) begin
        if (areset) begin
            drops_q <= '0;
        end else begin
            drops_q <= drops_d;
        end
    end

    assign sts_drops = drops_q;
`else
    assign sts_drops = '0;
`endif

    assign m_axis_tdata  = mem_q[rd_ptr_q];
    assign m_axis_tvalid = tvalid_q;
    assign det_inhibit   = det_inhibit_q;
    assign sts_state     = state_q;
    assign sts_events    = events_q;

endmodule

// File: tb/tb_axis_acquisition_controller.sv
// Self-checking bench for axis_acquisition_controller against a queue-based
// behavioural model of the acquisition run.
module tb_axis_acquisition_controller;

    localparam int unsigned AW    = 4;
    localparam int unsigned DEPTH = 16;
`ifdef AXIS_ACQUISITION_CONTROLLER_DROP_CNT_EN
    localparam bit DROP_EN = 1'b1;
`else
    localparam bit DROP_EN = 1'b0;
`endif

    logic         aclk = 1'b0;
    logic         areset;
    logic [63:0]  cfg_time;
    logic [31:0]  cfg_events;
    logic         ctrl_start;
    logic         ctrl_stop;
    logic [127:0] s_axis_tdata;
    logic         s_axis_tvalid;
    logic [127:0] m_axis_tdata;
    logic         m_axis_tvalid;
    logic         m_axis_tready;
    logic         det_inhibit;
    logic [1:0]   sts_state;
    logic [31:0]  sts_events;
    logic [31:0]  sts_drops;

    always #5 aclk = ~aclk;

    axis_acquisition_controller #(.FIFO_ADDR_WIDTH(AW)) dut (
        .aclk          (aclk),
        .areset        (areset),
        .cfg_time      (cfg_time),
        .cfg_events    (cfg_events),
        .ctrl_start    (ctrl_start),
        .ctrl_stop     (ctrl_stop),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .det_inhibit   (det_inhibit),
        .sts_state     (sts_state),
        .sts_events    (sts_events),
        .sts_drops     (sts_drops)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: run phase (0 idle, 1 run, 2 drain, 3 done), counters, buffer contents.
    int              m_state = 0;
    longint unsigned m_timer = 0;
    int unsigned     m_events = 0;
    int unsigned     m_drops = 0;
    logic [127:0]    m_q[$];
    logic [127:0]    out_q[$];

    logic [67:0] dut_status;
    assign dut_status = {sts_state, det_inhibit, m_axis_tvalid, sts_events, sts_drops};

    function automatic logic [67:0] exp_status();
        logic [31:0] d;
        d = DROP_EN ? m_drops : 32'd0;
        return {2'(m_state), (m_state != 1), (m_q.size() != 0), m_events, d};
    endfunction

    function automatic logic [127:0] exp_head();
        return (m_q.size() != 0) ? m_q[0] : 128'd0;
    endfunction

    function automatic logic [127:0] dut_head();
        return (m_q.size() != 0) ? m_axis_tdata : 128'd0;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic idle_inputs();
        ctrl_start    = 1'b0;
        ctrl_stop     = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        m_axis_tready = 1'b1;
    endtask

    // One clock: evaluate the model on the current inputs, record any handshake, advance.
    task automatic tick();
        int              n_state;
        longint unsigned n_timer;
        int unsigned     n_ev;
        int unsigned     n_dr;
        bit              do_pop;
        bit              do_push;
        logic [127:0]    din;
        logic [127:0]    junk;
        n_state = m_state;
        n_timer = m_timer;
        n_ev    = m_events;
        n_dr    = m_drops;
        do_push = 1'b0;
        do_pop  = (m_q.size() != 0) && m_axis_tready;
        din     = s_axis_tdata;
        if (m_axis_tvalid === 1'b1 && m_axis_tready) out_q.push_back(m_axis_tdata);
        if (areset) begin
            n_state = 0; n_timer = 0; n_ev = 0; n_dr = 0;
        end else begin
            case (m_state)
                0, 3: if (ctrl_start && cfg_time != 0 && !ctrl_stop) begin
                    n_state = 1; n_timer = 0; n_ev = 0; n_dr = 0;
                end
                1: begin
                    n_timer = m_timer + 1;
                    if (s_axis_tvalid) begin
                        if (m_q.size() < DEPTH) begin
                            do_push = 1'b1;
                            if (n_ev != 32'hffff_ffff) n_ev = n_ev + 1;
                        end else if (n_dr != 32'hffff_ffff) begin
                            n_dr = n_dr + 1;
                        end
                    end
                    if (ctrl_stop || n_timer >= cfg_time ||
                        (cfg_events != 0 && do_push && n_ev == cfg_events))
                        n_state = 2;
                end
                2: if (m_q.size() == 0) n_state = 3;
                default: n_state = 0;
            endcase
        end
        @(posedge aclk);
        #1;
        if (areset) begin
            m_q.delete();
        end else begin
            if (do_pop) junk = m_q.pop_front();
            if (do_push) m_q.push_back(din);
        end
        m_state  = n_state;
        m_timer  = n_timer;
        m_events = n_ev;
        m_drops  = n_dr;
    endtask

    task automatic test_reset();
        idle_inputs();
        cfg_time   = 64'd10;
        cfg_events = 32'd0;
        areset     = 1'b1;
        tick();
        tick();
        checks++;
        if (sts_state !== 2'd0 || det_inhibit !== 1'b1 || m_axis_tvalid !== 1'b0 ||
            sts_events !== 32'd0 || sts_drops !== 32'd0) begin
            failures++;
            $display("FAIL reset_values got st=%0d inh=%b tv=%b ev=%0d dr=%0d want 0 1 0 0 0",
                     sts_state, det_inhibit, m_axis_tvalid, sts_events, sts_drops);
        end
        areset = 1'b0;
        tick();
        checks++;
        if (dut_status !== exp_status()) begin
            failures++;
            $display("FAIL reset_release got %h want %h", dut_status, exp_status());
        end
    endtask

    task automatic test_basic();
        logic [127:0] sent[$];
        int low = 0;
        out_q.delete();
        cfg_time = 64'd10; cfg_events = 32'd0; m_axis_tready = 1'b1;
        for (int i = 0; i < 25; i++) begin
            ctrl_start = (i == 0);
            s_axis_tvalid = 1'b1;
            s_axis_tdata = rnd128();
            if (i >= 1 && i <= 10) sent.push_back(s_axis_tdata);
            tick();
            if (det_inhibit === 1'b0) low++;
            checks++;
            if (dut_status !== exp_status() || dut_head() !== exp_head()) begin
                failures++;
                $display("FAIL basic_cyc%0d got %h/%h want %h/%h", i, dut_status, dut_head(), exp_status(), exp_head());
            end
        end
        idle_inputs();
        checks++;
        if (low != 10) begin failures++; $display("FAIL basic_inhibit_low got %0d want 10", low); end
        checks++;
        if (out_q.size() != 10) begin failures++; $display("FAIL basic_out_count got %0d want 10", out_q.size()); end
        for (int k = 0; k < 10 && k < out_q.size(); k++) begin
            checks++;
            if (out_q[k] !== sent[k]) begin
                failures++;
                $display("FAIL basic_order%0d got %h want %h", k, out_q[k], sent[k]);
            end
        end
        checks++;
        if (sts_events !== 32'd10 || sts_state !== 2'd3) begin
            failures++;
            $display("FAIL basic_final got ev=%0d st=%0d want 10 3", sts_events, sts_state);
        end
    endtask

    task automatic test_event_limit();
        logic [127:0] sent[$];
        out_q.delete();
        cfg_time = 64'd1000; cfg_events = 32'd3; m_axis_tready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            ctrl_start = (i == 0);
            s_axis_tvalid = (i == 2 || i == 5 || i == 9 || (i >= 10 && i <= 14));
            s_axis_tdata = rnd128();
            if (i == 2 || i == 5 || i == 9) sent.push_back(s_axis_tdata);
            tick();
            checks++;
            if (dut_status !== exp_status() || dut_head() !== exp_head()) begin
                failures++;
                $display("FAIL evlim_cyc%0d got %h want %h", i, dut_status, exp_status());
            end
            if (i == 8 || i == 9) begin
                checks++;
                if (sts_state !== ((i == 8) ? 2'd1 : 2'd2)) begin
                    failures++;
                    $display("FAIL evlim_state_cyc%0d got %0d want %0d", i, sts_state, (i == 8) ? 1 : 2);
                end
            end
        end
        idle_inputs();
        checks++;
        if (sts_events !== 32'd3 || sts_state !== 2'd3 || out_q.size() != 3) begin
            failures++;
            $display("FAIL evlim_final got ev=%0d st=%0d out=%0d want 3 3 3", sts_events, sts_state, out_q.size());
        end
        for (int k = 0; k < 3 && k < out_q.size(); k++) begin
            checks++;
            if (out_q[k] !== sent[k]) begin
                failures++;
                $display("FAIL evlim_order%0d got %h want %h", k, out_q[k], sent[k]);
            end
        end
    endtask

    task automatic test_overflow();
        logic [127:0] sent[$];
        out_q.delete();
        cfg_time = 64'd20; cfg_events = 32'd0; m_axis_tready = 1'b0;
        for (int i = 0; i <= 20; i++) begin
            ctrl_start = (i == 0);
            s_axis_tvalid = (i >= 1);
            s_axis_tdata = rnd128();
            if (i >= 1) sent.push_back(s_axis_tdata);
            tick();
            checks++;
            if (dut_status !== exp_status() || dut_head() !== exp_head()) begin
                failures++;
                $display("FAIL ovf_cyc%0d got %h want %h", i, dut_status, exp_status());
            end
        end
        ctrl_start = 1'b0; s_axis_tvalid = 1'b0;
        checks++;
        if (sts_events !== 32'd16 || sts_drops !== (DROP_EN ? 32'd4 : 32'd0) || sts_state !== 2'd2) begin
            failures++;
            $display("FAIL ovf_counts got ev=%0d dr=%0d st=%0d want 16 %0d 2",
                     sts_events, sts_drops, sts_state, DROP_EN ? 4 : 0);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== sent[0]) begin
                failures++;
                $display("FAIL ovf_hold%0d got tv=%b %h want 1 %h", i, m_axis_tvalid, m_axis_tdata, sent[0]);
            end
        end
        m_axis_tready = 1'b1;
        for (int i = 0; i < 25; i++) begin
            tick();
            checks++;
            if (dut_status !== exp_status() || dut_head() !== exp_head()) begin
                failures++;
                $display("FAIL ovf_drain%0d got %h want %h", i, dut_status, exp_status());
            end
        end
        checks++;
        if (out_q.size() != 16 || sts_state !== 2'd3) begin
            failures++;
            $display("FAIL ovf_out got n=%0d st=%0d want 16 3", out_q.size(), sts_state);
        end
        for (int k = 0; k < 16 && k < out_q.size(); k++) begin
            checks++;
            if (out_q[k] !== sent[k]) begin
                failures++;
                $display("FAIL ovf_order%0d got %h want %h", k, out_q[k], sent[k]);
            end
        end
    endtask

    task automatic test_start_ignored();
        idle_inputs();
        areset = 1'b1; tick(); areset = 1'b0;
        cfg_time = 64'd10; ctrl_start = 1'b1; ctrl_stop = 1'b1;
        tick();
        checks++;
        if (sts_state !== 2'd0 || det_inhibit !== 1'b1) begin
            failures++;
            $display("FAIL ign_start_stop got st=%0d inh=%b want 0 1", sts_state, det_inhibit);
        end
        ctrl_stop = 1'b0; cfg_time = 64'd0;
        tick();
        checks++;
        if (sts_state !== 2'd0 || det_inhibit !== 1'b1) begin
            failures++;
            $display("FAIL ign_time0 got st=%0d inh=%b want 0 1", sts_state, det_inhibit);
        end
        ctrl_start = 1'b0;
    endtask

    task automatic test_stop();
        idle_inputs();
        cfg_time = 64'd1000; cfg_events = 32'd0;
        for (int i = 0; i < 20; i++) begin
            ctrl_start = (i == 0);
            ctrl_stop = (i == 4);
            s_axis_tvalid = (i >= 1 && i <= 6);
            s_axis_tdata = rnd128();
            tick();
            checks++;
            if (dut_status !== exp_status() || dut_head() !== exp_head()) begin
                failures++;
                $display("FAIL stop_cyc%0d got %h want %h", i, dut_status, exp_status());
            end
            if (i == 3 || i == 4) begin
                checks++;
                if (sts_state !== ((i == 3) ? 2'd1 : 2'd2)) begin
                    failures++;
                    $display("FAIL stop_state_cyc%0d got %0d want %0d", i, sts_state, (i == 3) ? 1 : 2);
                end
            end
        end
        idle_inputs();
        checks++;
        if (sts_state !== 2'd3 || sts_events !== 32'd4) begin
            failures++;
            $display("FAIL stop_final got st=%0d ev=%0d want 3 4", sts_state, sts_events);
        end
        ctrl_start = 1'b1;
        tick();
        ctrl_start = 1'b0;
        checks++;
        if (sts_state !== 2'd1 || sts_events !== 32'd0) begin
            failures++;
            $display("FAIL restart_clear got st=%0d ev=%0d want 1 0", sts_state, sts_events);
        end
        ctrl_stop = 1'b1; tick(); ctrl_stop = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (dut_status !== exp_status()) begin
            failures++;
            $display("FAIL restart_end got %h want %h", dut_status, exp_status());
        end
    endtask

    task automatic test_reset_midrun();
        logic [127:0] sent[$];
        idle_inputs();
        cfg_time = 64'd1000; cfg_events = 32'd0; m_axis_tready = 1'b0;
        for (int i = 0; i <= 5; i++) begin
            ctrl_start = (i == 0);
            s_axis_tvalid = (i >= 1);
            s_axis_tdata = rnd128();
            tick();
        end
        checks++;
        if (dut_status !== exp_status() || m_axis_tvalid !== 1'b1) begin
            failures++;
            $display("FAIL midrst_pre got %h want %h", dut_status, exp_status());
        end
        ctrl_start = 1'b0; s_axis_tvalid = 1'b0; areset = 1'b1;
        tick();
        checks++;
        if (m_axis_tvalid !== 1'b0 || sts_state !== 2'd0 || sts_events !== 32'd0) begin
            failures++;
            $display("FAIL midrst_out got tv=%b st=%0d ev=%0d want 0 0 0", m_axis_tvalid, sts_state, sts_events);
        end
        areset = 1'b0; m_axis_tready = 1'b1; cfg_time = 64'd8;
        out_q.delete();
        for (int i = 0; i < 20; i++) begin
            ctrl_start = (i == 0);
            s_axis_tvalid = (i >= 1 && i <= 3);
            s_axis_tdata = rnd128();
            if (i >= 1 && i <= 3) sent.push_back(s_axis_tdata);
            tick();
            checks++;
            if (dut_status !== exp_status() || dut_head() !== exp_head()) begin
                failures++;
                $display("FAIL midrst_cyc%0d got %h want %h", i, dut_status, exp_status());
            end
        end
        idle_inputs();
        checks++;
        if (out_q.size() != 3) begin failures++; $display("FAIL midrst_count got %0d want 3", out_q.size()); end
        for (int k = 0; k < 3 && k < out_q.size(); k++) begin
            checks++;
            if (out_q[k] !== sent[k]) begin
                failures++;
                $display("FAIL midrst_order%0d got %h want %h", k, out_q[k], sent[k]);
            end
        end
    endtask

    task automatic test_random();
        idle_inputs();
        cfg_time = 64'd20; cfg_events = 32'd0;
        for (int i = 0; i < 1200; i++) begin
            ctrl_start    = ($urandom_range(0, 7) == 0);
            ctrl_stop     = ($urandom_range(0, 47) == 0);
            s_axis_tvalid = ($urandom_range(0, 2) != 0);
            s_axis_tdata  = rnd128();
            m_axis_tready = ((i / 100) % 2 == 1) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 15) == 0) cfg_time = 64'($urandom_range(0, 40));
            if ($urandom_range(0, 15) == 0) cfg_events = 32'($urandom_range(0, 10));
            tick();
            checks++;
            if (dut_status !== exp_status() || dut_head() !== exp_head()) begin
                failures++;
                $display("FAIL rand_cyc%0d got %h/%h want %h/%h", i, dut_status, dut_head(), exp_status(), exp_head());
            end
        end
        idle_inputs();
    endtask

    initial begin
        areset = 1'b1;
        cfg_time = '0;
        cfg_events = '0;
        idle_inputs();
        test_reset();
        test_basic();
        test_event_limit();
        test_overflow();
        test_start_ignored();
        test_stop();
        test_reset_midrun();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
